// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the IMEM req/ready handshake, and
// buffers one instruction (with skid) for the IF/ID register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  input  logic        IMEM_Ready,
  input  logic [31:0] IMEM_Data,
  output logic [31:0] PC_Out,
  output logic [31:0] PC_Plus_4_Out,
  output logic [31:0] Instr_Out,
  output logic        Instr_Valid
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc, r_pend_pc, r_skid;
  logic [31:0] r_instr, r_pc4;
  logic        r_valid;

  logic [31:0] w_redir_pc, w_pc_plus4;
  logic        w_free, w_consume;

  assign w_redir_pc = {Redirect_PC[31:2], 2'b00};
  assign w_pc_plus4 = r_fetch_pc + 32'd4;
  assign w_free     = !r_valid || !STALL;
  assign w_consume  = r_valid && !STALL;

  // Gated by RST so an in-flight request is abandoned the moment reset rises.
  assign IMEM_Req      = !RST && (r_state != S_HOLD);
  assign IMEM_Addr     = r_fetch_pc;
  assign PC_Out        = r_fetch_pc;
  assign PC_Plus_4_Out = r_pc4;
  assign Instr_Out     = r_instr;
  assign Instr_Valid   = r_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= 32'd0;
      r_skid     <= 32'd0;
      r_instr    <= 32'd0;
      r_pc4      <= 32'd0;
      r_valid    <= 1'b0;
    end else begin
      if (w_consume) begin
        r_valid <= 1'b0;
        r_instr <= 32'd0;
      end
      case (r_state)
        S_FETCH: begin
          if (IMEM_Ready) begin
            if (Redirect) begin
              r_fetch_pc <= w_redir_pc;
            end else if (w_free) begin
              r_instr    <= IMEM_Data;
              r_pc4      <= w_pc_plus4;
              r_valid    <= 1'b1;
              r_fetch_pc <= w_pc_plus4;
            end else begin
              r_skid     <= IMEM_Data;
              r_fetch_pc <= w_pc_plus4;
              r_state    <= S_HOLD;
            end
          end else if (Redirect) begin
            // Address must stay stable until Ready, so park the target.
            r_pend_pc <= w_redir_pc;
            r_state   <= S_DROP;
          end
        end
        S_HOLD: begin
          if (Redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_state    <= S_FETCH;
          end else if (!STALL) begin
            r_instr <= r_skid;
            r_pc4   <= r_fetch_pc;
            r_valid <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_DROP: begin
          if (IMEM_Ready) begin
            r_fetch_pc <= Redirect ? w_redir_pc : r_pend_pc;
            r_state    <= S_FETCH;
          end else if (Redirect) begin
            r_pend_pc <= w_redir_pc;
          end
        end
        default: r_state <= S_FETCH;
      endcase
      // A redirect flushes the buffer regardless of STALL.
      if (Redirect) begin
        r_valid <= 1'b0;
        r_instr <= 32'd0;
        r_pc4   <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, wait states, stall/skid,
// redirects (including during a pending request) and PC wrap / async reset.
module tb_if_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RST2 = 1'b1;
  logic        STALL = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Redirect_PC = 32'd0;
  logic        IMEM_Ready = 1'b0;
  logic [31:0] IMEM_Data = 32'd0;

  logic        a_req, a_valid;
  logic [31:0] a_addr, a_pc, a_pc4, a_instr;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_pc, b_pc4, b_instr;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  if_fetch_stage dut_a (
    .CLK(CLK), .RST(RST), .STALL(STALL), .Redirect(Redirect),
    .Redirect_PC(Redirect_PC), .IMEM_Req(a_req), .IMEM_Addr(a_addr),
    .IMEM_Ready(IMEM_Ready), .IMEM_Data(IMEM_Data), .PC_Out(a_pc),
    .PC_Plus_4_Out(a_pc4), .Instr_Out(a_instr), .Instr_Valid(a_valid)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .CLK(CLK), .RST(RST2), .STALL(STALL), .Redirect(Redirect),
    .Redirect_PC(Redirect_PC), .IMEM_Req(b_req), .IMEM_Addr(b_addr),
    .IMEM_Ready(IMEM_Ready), .IMEM_Data(IMEM_Data), .PC_Out(b_pc),
    .PC_Plus_4_Out(b_pc4), .Instr_Out(b_instr), .Instr_Valid(b_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Checks the A-instance output buffer in one call.
  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] p4);
    chk({tag, ".valid"}, {31'd0, a_valid}, {31'd0, v});
    chk({tag, ".instr"}, a_instr, ins);
    chk({tag, ".pc4"}, a_pc4, p4);
  endtask

  initial begin
    step(); step();
    chk("rst.req", {31'd0, a_req}, 32'd0);
    chk_out("rst", 1'b0, 32'd0, 32'd0);
    chk("rst.pc", a_pc, 32'd0);

    // Zero-wait streaming
    RST = 1'b0;
    #1;
    chk("zw.req", {31'd0, a_req}, 32'd1);
    chk("zw.addr0", a_addr, 32'h0);
    IMEM_Ready = 1'b1; IMEM_Data = 32'h0;
    step();
    chk_out("zw0", 1'b1, 32'h0, 32'h4);
    chk("zw.addr1", a_addr, 32'h4);
    IMEM_Data = 32'h4;
    step();
    chk_out("zw1", 1'b1, 32'h4, 32'h8);
    chk("zw.addr2", a_addr, 32'h8);
    IMEM_Data = 32'h8;
    step();
    chk_out("zw2", 1'b1, 32'h8, 32'hC);
    IMEM_Ready = 1'b0;
    step();
    chk_out("zw.drain", 1'b0, 32'h0, 32'hC);

    // Two wait states at 0xC
    for (int k = 0; k < 3; k++) begin
      chk("ws.addr", a_addr, 32'hC);
      chk("ws.req", {31'd0, a_req}, 32'd1);
      chk("ws.valid", {31'd0, a_valid}, 32'd0);
      IMEM_Ready = (k == 2); IMEM_Data = 32'hC;
      step();
    end
    chk_out("ws.pulse", 1'b1, 32'hC, 32'h10);
    IMEM_Ready = 1'b0;
    step();
    chk_out("ws.gap", 1'b0, 32'h0, 32'h10);

    // Stall with a response arriving -> skid
    IMEM_Ready = 1'b1; IMEM_Data = 32'h10;
    step();
    chk_out("st.pre", 1'b1, 32'h10, 32'h14);
    STALL = 1'b1; IMEM_Data = 32'h14;
    step();
    IMEM_Ready = 1'b0;
    chk("st.req0", {31'd0, a_req}, 32'd0);
    chk_out("st.hold0", 1'b1, 32'h10, 32'h14);
    step();
    chk("st.req1", {31'd0, a_req}, 32'd0);
    step();
    chk_out("st.hold2", 1'b1, 32'h10, 32'h14);
    STALL = 1'b0;
    step();
    chk_out("st.skid", 1'b1, 32'h14, 32'h18);
    chk("st.req2", {31'd0, a_req}, 32'd1);
    chk("st.addr", a_addr, 32'h18);
    IMEM_Ready = 1'b1; IMEM_Data = 32'h18;
    step();
    chk_out("st.next", 1'b1, 32'h18, 32'h1C);
    IMEM_Ready = 1'b0;
    step();

    // Redirect during an outstanding request at 0x1C
    Redirect = 1'b1; Redirect_PC = 32'h100;
    step();
    Redirect = 1'b0;
    chk("rd.addr0", a_addr, 32'h1C);
    chk("rd.req0", {31'd0, a_req}, 32'd1);
    step();
    chk("rd.addr1", a_addr, 32'h1C);
    IMEM_Ready = 1'b1; IMEM_Data = 32'hDEAD_BEEF;
    step();
    chk("rd.addr2", a_addr, 32'h100);
    chk_out("rd.drop", 1'b0, 32'h0, 32'h0);
    IMEM_Data = 32'h100;
    step();
    chk_out("rd.new", 1'b1, 32'h100, 32'h104);

    // Redirect with STALL clears the buffer; multiple redirects in DROP
    IMEM_Ready = 1'b0; STALL = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h200;
    step();
    chk_out("mr.flush", 1'b0, 32'h0, 32'h0);
    chk("mr.addr0", a_addr, 32'h104);
    STALL = 1'b0; Redirect_PC = 32'h300;
    step();
    Redirect_PC = 32'h303;
    step();
    chk("mr.addr1", a_addr, 32'h104);
    Redirect = 1'b0; IMEM_Ready = 1'b1; IMEM_Data = 32'hBAD0_0000;
    step();
    chk("mr.addr2", a_addr, 32'h300);
    chk("mr.pc", a_pc, 32'h300);
    chk("mr.valid", {31'd0, a_valid}, 32'd0);

    // Ready and Redirect together in FETCH
    Redirect = 1'b1; Redirect_PC = 32'h400;
    step();
    Redirect = 1'b0; IMEM_Ready = 1'b0;
    chk("fr.addr", a_addr, 32'h400);
    chk("fr.valid", {31'd0, a_valid}, 32'd0);

    // Wrapping reset PC and asynchronous reset mid-request
    chk("wr.rst.req", {31'd0, b_req}, 32'd0);
    RST2 = 1'b0;
    #1;
    chk("wr.req", {31'd0, b_req}, 32'd1);
    chk("wr.addr0", b_addr, 32'hFFFF_FFFC);
    IMEM_Ready = 1'b1; IMEM_Data = 32'h0000_AAAA;
    step();
    chk("wr.instr", b_instr, 32'h0000_AAAA);
    chk("wr.pc4", b_pc4, 32'h0);
    chk("wr.addr1", b_addr, 32'h0);
    IMEM_Ready = 1'b0;
    step();
    #2;
    RST2 = 1'b1;
    #1;
    chk("ar.req", {31'd0, b_req}, 32'd0);
    chk("ar.addr", b_addr, 32'hFFFF_FFFC);
    chk("ar.valid", {31'd0, b_valid}, 32'd0);
    step();
    RST2 = 1'b0;
    #1;
    chk("ar.req2", {31'd0, b_req}, 32'd1);
    chk("ar.addr2", b_addr, 32'hFFFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
